soc_mgmt_rst_seq: RTL

Reset sequencer in soc_mgmt, directly downstream of the raw cold-reset driver. It synchronises the raw reset to i_clk and releases a set of partition resets in fixed ascending order with programmable gaps. It also services warm-reset requests that re-assert a selected subset of partitions and re-release them in order, with a completion handshake.

---
 rtl/soc_mgmt_rst_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/soc_mgmt_rst_seq.sv
// -----------------------------------------------------------------------------
// soc_mgmt_rst_seq
//
// Reset sequencer placed directly behind the raw cold-reset driver. The raw
// reset is synchronised to i_clk, then the partition resets are released one
// at a time in ascending index order, ReleaseGap cycles apart. In IDLE, a
// warm-reset request re-asserts a chosen subset of partitions, holds them for
// AssertHoldCycles cycles, then releases them again in order and answers with
// a one-cycle acknowledge.
//
// Ports
//   i_clk           sequencer clock
//   i_drv_rst       cold reset, asynchronous, active-high
//   i_warm_rst_req  warm-reset request level (held until o_warm_rst_ack)
//   i_stage_mask    stages affected by a warm reset, sampled at acceptance
//   o_rst_n         per-stage active-low partition resets
//   o_warm_rst_ack  one-cycle pulse when a warm-reset sequence completes
//   o_busy          high whenever the sequencer is not in IDLE
//   o_state         FSM state: SYNC=0, RELEASE=1, IDLE=2, HOLD=3
// -----------------------------------------------------------------------------
module soc_mgmt_rst_seq #(
   parameter int NumStages        = 4,
   parameter int SyncStages       = 3,
   parameter int ReleaseGap       = 8,
   parameter int AssertHoldCycles = 16
) (
   input  logic                 i_clk,
   input  logic                 i_drv_rst,
   input  logic                 i_warm_rst_req,
   input  logic [NumStages-1:0] i_stage_mask,
   output logic [NumStages-1:0] o_rst_n,
   output logic                 o_warm_rst_ack,
   output logic                 o_busy,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_IDLE    = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   localparam int MaxCnt = (ReleaseGap > AssertHoldCycles) ? ReleaseGap : AssertHoldCycles;
   localparam int CntW   = $clog2(MaxCnt + 1);

   // A counter loaded with N-1 reaches zero N-1 edges later, so the action
   // taken on the zero edge lands exactly N edges after the load edge.
   localparam logic [CntW-1:0]      GapLoad   = CntW'(ReleaseGap - 1);
   localparam logic [CntW-1:0]      HoldLoad  = CntW'(AssertHoldCycles - 1);
   localparam logic [CntW-1:0]      CntZero   = {CntW{1'b0}};
   localparam logic [CntW-1:0]      CntOne    = CntW'(1);
   localparam logic [NumStages-1:0] StageZero = {NumStages{1'b0}};
   localparam logic [NumStages-1:0] StageOne  = NumStages'(1);

   logic [SyncStages-1:0] sync_r;
   logic                  sync_s;

   state_e                state_r, state_n;
   logic [NumStages-1:0]  rst_n_r, rst_n_n;
   logic [NumStages-1:0]  pend_r,  pend_n;   // stages still waiting for release
   logic [CntW-1:0]       cnt_r,   cnt_n;
   logic                  warm_r,  warm_n;   // current sequence is a warm reset
   logic                  ack_r,   ack_n;
   logic                  busy_r,  busy_n;
   logic [NumStages-1:0]  low_s;             // lowest pending stage, one-hot

   // Reset synchroniser: cleared asynchronously, shifts in ones after release.
   always_ff @(posedge i_clk or posedge i_drv_rst) begin
      if (i_drv_rst) begin
         sync_r <= {SyncStages{1'b0}};
      end else begin
         sync_r <= {sync_r[SyncStages-2:0], 1'b1};
      end
   end

   assign sync_s = sync_r[SyncStages-1];

   // Isolate the lowest set bit; unmasked stages are simply absent from
   // pend_r, so they are skipped without costing any gap time.
   assign low_s = pend_r & (~pend_r + StageOne);

   // Sequencer state and registered outputs.
   always_ff @(posedge i_clk or posedge i_drv_rst) begin
      if (i_drv_rst) begin
         state_r <= ST_SYNC;
         rst_n_r <= StageZero;
         pend_r  <= StageZero;
         cnt_r   <= CntZero;
         warm_r  <= 1'b0;
         ack_r   <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         state_r <= state_n;
         rst_n_r <= rst_n_n;
         pend_r  <= pend_n;
         cnt_r   <= cnt_n;
         warm_r  <= warm_n;
         ack_r   <= ack_n;
         busy_r  <= busy_n;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n = state_r;
      rst_n_n = rst_n_r;
      pend_n  = pend_r;
      cnt_n   = cnt_r;
      warm_n  = warm_r;
      ack_n   = 1'b0;

      case (state_r)
         ST_SYNC: begin
            if (sync_s) begin
               // Stage 0 leaves reset as soon as the synchroniser settles.
               rst_n_n = StageOne;
               pend_n  = ~StageOne;
               cnt_n   = GapLoad;
               warm_n  = 1'b0;
               if (pend_n == StageZero) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_RELEASE;
               end
            end else begin
               state_n = ST_SYNC;
            end
         end

         // HOLD and RELEASE share the countdown; on expiry both release the
         // lowest pending stage, so the end of HOLD is just the first release.
         ST_RELEASE, ST_HOLD: begin
            if (cnt_r == CntZero) begin
               rst_n_n = rst_n_r | low_s;
               pend_n  = pend_r & ~low_s;
               cnt_n   = GapLoad;
               if (pend_n == StageZero) begin
                  state_n = ST_IDLE;
                  ack_n   = warm_r;
               end else begin
                  state_n = ST_RELEASE;
               end
            end else begin
               cnt_n = cnt_r - CntOne;
            end
         end

         ST_IDLE: begin
            // No acceptance during the ack cycle, so a level still held after
            // ack starts a fresh sequence one cycle later.
            if (i_warm_rst_req && !ack_r) begin
               if (i_stage_mask == StageZero) begin
                  ack_n = 1'b1;
               end else begin
                  rst_n_n = rst_n_r & ~i_stage_mask;
                  pend_n  = i_stage_mask;
                  cnt_n   = HoldLoad;
                  warm_n  = 1'b1;
                  state_n = ST_HOLD;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end

         default: begin
            state_n = ST_SYNC;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   assign o_rst_n        = rst_n_r;
   assign o_warm_rst_ack = ack_r;
   assign o_busy         = busy_r;
   assign o_state        = state_r;

endmodule
